// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the round-robin operand-mux arbiter.
package mux_rr_arbiter_pkg;

   localparam int N_REQ  = 8;
   localparam int SEL_W  = 3;
   localparam int HCNT_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
      idx_to_onehot      = '0;
      idx_to_onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bus of the arbiter: request lines and data words in, grant/select/data out.
interface mux_rr_arbiter_if #(
   parameter int WIDTH = 6
);
   import mux_rr_arbiter_pkg::*;

   logic [N_REQ-1:0]       REQ;
   logic [N_REQ*WIDTH-1:0] D_BUS;
   logic [N_REQ-1:0]       GNT;
   logic [SEL_W-1:0]       SEL;
   logic [WIDTH-1:0]       OUT;
   logic                   VALID;

   modport master (
      output REQ,
      output D_BUS,
      input  GNT,
      input  SEL,
      input  OUT,
      input  VALID
   );

   modport slave (
      input  REQ,
      input  D_BUS,
      output GNT,
      output SEL,
      output OUT,
      output VALID
   );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick_8.sv
// Rotating-priority encoder: first set request scanning from ptr upward modulo 8,
// optionally ignoring one index (used to pass over the current holder).
module rr_pick_8
   import mux_rr_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [SEL_W-1:0] ptr_i,
   input  logic             excl_en_i,
   input  logic [SEL_W-1:0] excl_idx_i,
   output logic             any_o,
   output logic [SEL_W-1:0] idx_o
);

   logic [N_REQ-1:0] masked;
   logic [SEL_W-1:0] cand;

   // Scan from the farthest offset down so the candidate closest to ptr is written last.
   always_comb begin
      masked = req_i;
      if (excl_en_i) begin
         masked[excl_idx_i] = 1'b0;
      end
      any_o = 1'b0;
      idx_o = '0;
      cand  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr_i + SEL_W'(k);
         if (masked[cand]) begin
            any_o = 1'b1;
            idx_o = cand;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing an 8:1 operand mux; registers the winner's word with VALID.
// Optional hold limit compiled in with `define ARB_HOLD_LIMIT_EN (uses MAX_HOLD).
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int WIDTH    = 6,
   parameter int MAX_HOLD = 4
) (
   input  logic CLK,
   input  logic RST_N,
   mux_rr_arbiter_if.slave bus
);

   if (MAX_HOLD < 1 || MAX_HOLD > (1 << HCNT_W) - 1) begin : g_bad_max_hold
      $error("mux_rr_arbiter: MAX_HOLD must lie in 1..255");
   end

   arb_state_e       state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             valid_q, valid_d;

   logic [SEL_W-1:0] next_ptr;
   logic [SEL_W-1:0] pick_ptr;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic             excl_en;
   logic             req_g;
   logic             rel_g;
   logic             rotate;
   logic             load;
   logic             keep;
   logic             go_idle;

   // sel_q always names the current (or last) winner g.
   assign req_g    = bus.REQ[sel_q];
   assign next_ptr = sel_q + SEL_W'(1);
   assign rel_g    = (state_q == ST_GRANT) && !req_g;
   assign excl_en  = (state_q == ST_GRANT);
   assign pick_ptr = (state_q == ST_GRANT) ? next_ptr : ptr_q;

   rr_pick_8 u_pick (
      .req_i      (bus.REQ),
      .ptr_i      (pick_ptr),
      .excl_en_i  (excl_en),
      .excl_idx_i (sel_q),
      .any_o      (pick_any),
      .idx_o      (pick_idx)
   );

`ifdef ARB_HOLD_LIMIT_EN
   localparam logic [HCNT_W-1:0] HOLD_LIM = HCNT_W'(MAX_HOLD);

   logic [HCNT_W-1:0] hcnt_q, hcnt_d;

   assign rotate = (state_q == ST_GRANT) && req_g && (hcnt_q == HOLD_LIM)
                   && |(bus.REQ & ~gnt_q);

   // At the limit with nobody else waiting the holder simply restarts its count.
   always_comb begin
      hcnt_d = hcnt_q;
      if (load) begin
         hcnt_d = HCNT_W'(1);
      end else if (keep) begin
         if (hcnt_q == HOLD_LIM) begin
            hcnt_d = HCNT_W'(1);
         end else if (hcnt_q != '1) begin
            hcnt_d = hcnt_q + HCNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
      end
   end
`else
   assign rotate = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         sel_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   // A release (or forced rotation) re-picks from g+1 on the same edge, so no bubble.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      load    = 1'b0;
      keep    = 1'b0;
      go_idle = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d = ST_GRANT;
               load    = 1'b1;
            end
         end
         ST_GRANT: begin
            if (rel_g || rotate) begin
               ptr_d = next_ptr;
               if (pick_any) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  go_idle = 1'b1;
               end
            end else begin
               keep = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      out_d   = out_q;
      valid_d = valid_q;
      if (load) begin
         gnt_d   = idx_to_onehot(pick_idx);
         sel_d   = pick_idx;
         out_d   = bus.D_BUS[int'(pick_idx) * WIDTH +: WIDTH];
         valid_d = 1'b1;
      end else if (keep) begin
         out_d = bus.D_BUS[int'(sel_q) * WIDTH +: WIDTH];
      end else if (go_idle) begin
         gnt_d   = '0;
         valid_d = 1'b0;
      end
   end

   assign bus.GNT   = gnt_q;
   assign bus.SEL   = sel_q;
   assign bus.OUT   = out_q;
   assign bus.VALID = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter; expected grant/select/data values are worked out by hand.
module tb_mux_rr_arbiter;

   localparam int W = 6;

   logic CLK;
   logic RST_N;
   int   vectors;
   int   miscompares;

   mux_rr_arbiter_if #(.WIDTH(W)) bus ();

   mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic setData(input int idx, input logic [W-1:0] val);
      bus.D_BUS[idx*W +: W] = val;
   endtask

   // Inputs change on the falling edge; one rising edge later we sit on the next falling edge.
   task automatic applyStimulus(input logic [7:0] req);
      bus.REQ = req;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] eGnt, input logic [2:0] eSel,
                              input logic [W-1:0] eOut, input logic eValid);
      vectors++;
      assert ({bus.GNT, bus.SEL, bus.OUT, bus.VALID} === {eGnt, eSel, eOut, eValid})
      else begin
         miscompares++;
         $error("[TB] FAIL %s: got gnt=%b sel=%0d out=%0d valid=%b, expected gnt=%b sel=%0d out=%0d valid=%b",
                tag, bus.GNT, bus.SEL, bus.OUT, bus.VALID, eGnt, eSel, eOut, eValid);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      RST_N       = 1'b1;
      bus.REQ     = '0;
      for (int i = 0; i < 8; i++) begin
         setData(i, W'(10 + i));
      end
      #1 RST_N = 1'b0;
      #1 checkOutput("reset", 8'h00, 3'd0, 6'd0, 1'b0);
      @(negedge CLK);
      RST_N = 1'b1;
      applyStimulus(8'h00);
      checkOutput("idle_after_reset", 8'h00, 3'd0, 6'd0, 1'b0);

      // Single requester and data tracking
      setData(2, 6'd2);
      applyStimulus(8'h04);
      checkOutput("single_grant", 8'h04, 3'd2, 6'd2, 1'b1);
      setData(2, 6'd9);
      applyStimulus(8'h04);
      checkOutput("data_track", 8'h04, 3'd2, 6'd9, 1'b1);

      // Asynchronous reset in the middle of a grant
      RST_N = 1'b0;
      #1 checkOutput("reset_mid_grant", 8'h00, 3'd0, 6'd0, 1'b0);
      RST_N = 1'b1;
      setData(2, 6'd12);

      // Full round robin, each requester drops one cycle after being granted
      for (int k = 0; k < 8; k++) begin
         applyStimulus(8'hFF << k);
         checkOutput($sformatf("rr_grant_%0d", k), 8'(1 << k), 3'(k), 6'(10 + k), 1'b1);
      end
      applyStimulus(8'h01);
      checkOutput("rr_wrap_to_0", 8'h01, 3'd0, 6'd10, 1'b1);
      applyStimulus(8'h00);
      checkOutput("rr_release_idle", 8'h00, 3'd0, 6'd10, 1'b0);

      // Wrap-around after winner 6 and from pointer 7
      applyStimulus(8'h40);
      checkOutput("wrap_grant_6", 8'h40, 3'd6, 6'd16, 1'b1);
      applyStimulus(8'h81);
      checkOutput("wrap_grant_7", 8'h80, 3'd7, 6'd17, 1'b1);
      applyStimulus(8'h01);
      checkOutput("wrap_grant_0", 8'h01, 3'd0, 6'd10, 1'b1);
      applyStimulus(8'h00);
      applyStimulus(8'h40);
      checkOutput("regrant_6", 8'h40, 3'd6, 6'd16, 1'b1);
      applyStimulus(8'h00);
      checkOutput("idle_ptr7", 8'h00, 3'd6, 6'd16, 1'b0);
      applyStimulus(8'h81);
      checkOutput("ptr7_prefers_7", 8'h80, 3'd7, 6'd17, 1'b1);
      applyStimulus(8'h01);
      checkOutput("ptr0_after_7", 8'h01, 3'd0, 6'd10, 1'b1);

      // Back-to-back handoff to requester 3, then release to idle
      applyStimulus(8'h08);
      checkOutput("grant_3", 8'h08, 3'd3, 6'd13, 1'b1);
      applyStimulus(8'h00);
      checkOutput("release_3_idle", 8'h00, 3'd3, 6'd13, 1'b0);
      applyStimulus(8'h00);
      checkOutput("idle_hold_3", 8'h00, 3'd3, 6'd13, 1'b0);

`ifdef ARB_HOLD_LIMIT_EN
      // Two persistent requesters alternate every four cycles
      for (int s = 0; s < 12; s++) begin
         applyStimulus(8'h03);
         if (((s / 4) % 2) == 0) begin
            checkOutput($sformatf("hold_cycle_%0d", s), 8'h01, 3'd0, 6'd10, 1'b1);
         end else begin
            checkOutput($sformatf("hold_cycle_%0d", s), 8'h02, 3'd1, 6'd11, 1'b1);
         end
      end
      for (int s = 0; s < 6; s++) begin
         applyStimulus(8'h01);
         checkOutput($sformatf("hold_alone_%0d", s), 8'h01, 3'd0, 6'd10, 1'b1);
      end
`else
      // Without a hold limit requester 0 keeps the grant while requester 1 waits
      for (int s = 0; s < 10; s++) begin
         applyStimulus(8'h03);
         checkOutput($sformatf("no_limit_%0d", s), 8'h01, 3'd0, 6'd10, 1'b1);
      end
      applyStimulus(8'h02);
      checkOutput("no_limit_handoff", 8'h02, 3'd1, 6'd11, 1'b1);
`endif

      applyStimulus(8'h00);
      checkOutput("final_idle_valid", {bus.GNT}, bus.SEL, bus.OUT, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
